// File: rtl/instruction_loader_if.sv
// Byte-stream and instruction-memory write bus of the instruction loader.
// The master drives the stream (start/byte_in/byte_valid); the slave is the loader.
interface instruction_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addy;
    logic [31:0]           mem_data;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH-1:0] words_loaded;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addy, mem_data, cpu_hold, done, error, words_loaded
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addy, mem_data, cpu_hold, done, error, words_loaded
    );
endinterface

// File: rtl/instruction_loader.sv
// Loads a program from a byte stream (16-bit word count header, then MSB-first
// 32-bit words) into instruction memory from address 0, holding the CPU meanwhile.
module instruction_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 31
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            hdr_hi_q, hdr_hi_d;
    logic [15:0]           count_q, count_d;
    logic [23:0]           word_q, word_d;        // first three bytes of the word in flight
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH-1:0] words_loaded_q, words_loaded_d;
    logic [ADDR_WIDTH-1:0] mem_addy_q, mem_addy_d;
    logic [31:0]           mem_data_q, mem_data_d;

    logic [15:0]           header_n;
    logic [15:0]           next_count;

    assign header_n   = {hdr_hi_q, bus.byte_in};
    assign next_count = 16'(words_loaded_q) + 16'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            hdr_hi_q       <= '0;
            count_q        <= '0;
            word_q         <= '0;
            byte_idx_q     <= '0;
            words_loaded_q <= '0;
            mem_addy_q     <= '0;
            mem_data_q     <= '0;
        end else begin
            state_q        <= state_d;
            hdr_hi_q       <= hdr_hi_d;
            count_q        <= count_d;
            word_q         <= word_d;
            byte_idx_q     <= byte_idx_d;
            words_loaded_q <= words_loaded_d;
            mem_addy_q     <= mem_addy_d;
            mem_data_q     <= mem_data_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        hdr_hi_d       = hdr_hi_q;
        count_d        = count_q;
        word_d         = word_q;
        byte_idx_d     = byte_idx_q;
        words_loaded_d = words_loaded_q;
        mem_addy_d     = mem_addy_q;
        mem_data_d     = mem_data_q;
        bus.byte_ready = 1'b0;
        bus.cpu_hold   = 1'b0;
        bus.mem_we     = 1'b0;
        bus.done       = 1'b0;
        bus.error      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d        = S_HDR_HI;
                    words_loaded_d = '0;
                end
            end
            S_HDR_HI: begin
                bus.byte_ready = 1'b1;
                bus.cpu_hold   = 1'b1;
                if (bus.byte_valid) begin
                    hdr_hi_d = bus.byte_in;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                bus.byte_ready = 1'b1;
                bus.cpu_hold   = 1'b1;
                if (bus.byte_valid) begin
                    count_d    = header_n;
                    byte_idx_d = '0;
                    if (header_n == 16'd0)             state_d = S_DONE;
                    else if (header_n > 16'(DEPTH))    state_d = S_ERROR;
                    else                               state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                bus.byte_ready = 1'b1;
                bus.cpu_hold   = 1'b1;
                if (bus.byte_valid) begin
                    word_d     = {word_q[15:0], bus.byte_in};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Write address/data are captured here so they hold after the pulse.
                        mem_addy_d = words_loaded_q;
                        mem_data_d = {word_q, bus.byte_in};
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                bus.cpu_hold   = 1'b1;
                bus.mem_we     = 1'b1;
                words_loaded_d = words_loaded_q + ADDR_WIDTH'(1);
                state_d        = (next_count == count_q) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    state_d        = S_HDR_HI;
                    words_loaded_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                bus.error = 1'b1;
                if (bus.start) begin
                    state_d        = S_HDR_HI;
                    words_loaded_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_addy     = mem_addy_q;
    assign bus.mem_data     = mem_data_q;
    assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued as the
// stream is driven and popped by a monitor on every mem_we pulse.
module tb_instruction_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int DEPTH      = 31;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    logic clock;
    logic reset;

    instruction_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    instruction_loader #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    wr_t         sb_q[$];
    logic [31:0] prog[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clock) begin
        if (bus.mem_we === 1'b1) begin
            check("write_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                check("mem_addy", 64'(bus.mem_addy), 64'(e.addr));
                check("mem_data", 64'(bus.mem_data), 64'(e.data));
            end
            check("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
            check("hold_in_write", 64'(bus.cpu_hold), 64'd1);
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            step();
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock);
            ok = bus.byte_ready;
            step();
        end
        bus.byte_valid = 1'b0;
        check("byte_accepted", 64'(ok), 64'd1);
    endtask

    task automatic send_header(input logic [15:0] n, input int maxgap);
        send_byte(n[15:8], $urandom_range(maxgap, 0));
        send_byte(n[7:0],  $urandom_range(maxgap, 0));
    endtask

    // Sends header plus every word in prog, queuing the expected writes.
    task automatic load_prog(input int maxgap);
        logic [15:0] n;
        logic [31:0] w;
        wr_t         e;
        n = 16'(prog.size());
        for (int i = 0; i < prog.size(); i++) begin
            e.addr = ADDR_WIDTH'(i);
            e.data = prog[i];
            sb_q.push_back(e);
        end
        send_header(n, maxgap);
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            send_byte(w[31:24], $urandom_range(maxgap, 0));
            send_byte(w[23:16], $urandom_range(maxgap, 0));
            send_byte(w[15:8],  $urandom_range(maxgap, 0));
            send_byte(w[7:0],   $urandom_range(maxgap, 0));
        end
    endtask

    task automatic wait_done(input string tag, input int exp_words);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            found = bus.done;
        end
        check(tag, 64'(found), 64'd1);
        check({tag, "_words"}, 64'(bus.words_loaded), 64'(exp_words));
        check({tag, "_hold"},  64'(bus.cpu_hold), 64'd0);
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    64'(bus.mem_we), 64'd0);
        check({tag, "_addy"},  64'(bus.mem_addy), 64'd0);
        check({tag, "_data"},  64'(bus.mem_data), 64'd0);
        check({tag, "_hold"},  64'(bus.cpu_hold), 64'd0);
        check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check({tag, "_done"},  64'(bus.done), 64'd0);
        check({tag, "_error"}, 64'(bus.error), 64'd0);
        check({tag, "_words"}, 64'(bus.words_loaded), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        repeat (3) step();
        @(negedge clock);
        check_all_zero("reset");
        step();
        reset = 1'b0;
        step();

        // Normal load, valid every cycle.
        prog = '{32'h5820_0000, 32'h5840_0000, 32'h2822_0005};
        d0 = done_cnt;
        do_start();
        @(negedge clock);
        check("hdr_hi_hold", 64'(bus.cpu_hold), 64'd1);
        check("hdr_hi_ready", 64'(bus.byte_ready), 64'd1);
        step();
        load_prog(0);
        wait_done("normal_done", 3);
        check("normal_one_done", 64'(done_cnt - d0), 64'd1);
        check("normal_drained", 64'(sb_q.size()), 64'd0);

        // Same stream with random gaps between bytes.
        d0 = done_cnt;
        do_start();
        load_prog(5);
        wait_done("gaps_done", 3);
        check("gaps_one_done", 64'(done_cnt - d0), 64'd1);
        check("gaps_drained", 64'(sb_q.size()), 64'd0);

        // Empty program: done the cycle after the second header byte.
        prog = {};
        do_start();
        load_prog(0);
        @(negedge clock);
        check("empty_done_next", 64'(bus.done), 64'd1);
        check("empty_words", 64'(bus.words_loaded), 64'd0);
        step();

        // Oversize header, then recovery by start.
        d0 = done_cnt;
        do_start();
        send_header(16'h0020, 0);
        @(negedge clock);
        check("over_error", 64'(bus.error), 64'd1);
        check("over_ready", 64'(bus.byte_ready), 64'd0);
        check("over_hold", 64'(bus.cpu_hold), 64'd0);
        step();
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h99;
        repeat (3) step();
        bus.byte_valid = 1'b0;
        @(negedge clock);
        check("over_error_held", 64'(bus.error), 64'd1);
        check("over_no_done", 64'(done_cnt - d0), 64'd0);
        step();
        do_start();
        @(negedge clock);
        check("over_error_cleared", 64'(bus.error), 64'd0);
        step();
        prog = '{32'h1122_3344};
        load_prog(1);
        wait_done("over_recover_done", 1);

        // Boundary: N == DEPTH.
        prog = {};
        for (int i = 0; i < DEPTH; i++) prog.push_back($urandom());
        do_start();
        load_prog(2);
        wait_done("full_done", DEPTH);
        check("full_drained", 64'(sb_q.size()), 64'd0);

        // Reset mid-word.
        do_start();
        send_header(16'h0002, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("midreset");
        step();
        prog = '{32'h0102_0304};
        do_start();
        load_prog(0);
        wait_done("after_reset_done", 1);

        check("final_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
